uart: RTL and testbench
=======================

UART -- requirements
Module: uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 234, clock cycles per bit; must be >= 4.
REQ-002 i_Clock  input  1  system clock; all state updates on its rising edge.
REQ-003 i_Reset  input  1  asynchronous, active-high reset.
REQ-004 i_Tx_DV  input  1  transmit request; sampled only while the transmitter is idle.
REQ-005 i_Tx_Byte  input  8  byte to transmit; captured on the cycle the request is accepted.
REQ-006 o_Tx_Active  output  1  high while a frame is being transmitted.
REQ-007 o_Tx_Serial  output  1  serial line, idle high.
REQ-008 o_Tx_Done  output  1  one-cycle pulse at the end of a frame.
REQ-009 i_Rx_Serial  input  1  asynchronous serial input, idle high.
REQ-010 o_Rx_DV  output  1  one-cycle pulse when a valid byte is received.
REQ-011 o_Rx_Byte  output  8  last valid received byte; held until the next valid frame.

Function
REQ-012 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each CLKS_PER_BIT cycles.
REQ-013 The transmitter SHALL use the states IDLE, START, DATA, STOP and CLEANUP.
REQ-014 Transmitter IDLE: o_Tx_Serial=1, o_Tx_Active=0; on a rising edge with i_Tx_DV=1 it latches i_Tx_Byte, sets o_Tx_Active=1 and enters START.
REQ-015 START: o_Tx_Serial=0 for CLKS_PER_BIT cycles. DATA: bit n driven for CLKS_PER_BIT cycles, n=0..7. STOP: o_Tx_Serial=1 for CLKS_PER_BIT cycles.
REQ-016 CLEANUP: one cycle with o_Tx_Done=1, o_Tx_Active=0 and o_Tx_Serial=1, then IDLE.
REQ-017 While o_Tx_Active=1, i_Tx_DV and i_Tx_Byte SHALL be ignored; changing i_Tx_Byte mid-frame does not alter the frame in progress.
REQ-018 If i_Tx_DV is held high, frames SHALL repeat back-to-back, each capturing i_Tx_Byte at its acceptance; the stop bit is followed by exactly 2 idle-high cycles (CLEANUP + IDLE) before the next start bit.
REQ-019 The receiver SHALL pass i_Rx_Serial through a 2-flop synchronizer (both flops reset to 1) and use only the synchronized value.
REQ-020 The receiver SHALL use the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-021 Receiver IDLE: on a synchronized 0, enter START and count (CLKS_PER_BIT-1)/2 cycles.
REQ-022 At the START midpoint, a 0 SHALL enter DATA; a 1 (glitch) SHALL return to IDLE with no output change.
REQ-023 DATA SHALL sample every CLKS_PER_BIT cycles from the start midpoint, shifting 8 bits in LSB first.
REQ-024 STOP SHALL sample after a further CLKS_PER_BIT cycles.
REQ-025 On a stop sample of 1: o_Rx_Byte is updated and o_Rx_DV=1 for exactly one cycle, in the same cycle; then IDLE.
REQ-026 On a stop sample of 0 (framing error): no o_Rx_DV, o_Rx_Byte unchanged, enter WAIT_IDLE until the synchronized line is 1, then IDLE.
REQ-027 Transmitter and receiver SHALL be fully independent; connecting o_Tx_Serial to i_Rx_Serial is a valid loopback.
REQ-028 Bit counters SHALL be wide enough for CLKS_PER_BIT-1, with no wrap-around within a bit period.

Reset
REQ-029 While i_Reset=1, independent of the clock: both FSMs in IDLE, all counters 0, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Rx_DV=0, o_Rx_Byte=8'h00, synchronizer flops=1.
REQ-030 Reset mid-frame SHALL abort the frame immediately, with no o_Tx_Done and no o_Rx_DV; after release both FSMs start from IDLE.

Verification
REQ-031 Loopback with CLKS_PER_BIT=234: pulse i_Tx_DV with 0x68 ('h') -> line shows 0,0,0,0,1,0,1,1,0,1, each 234 cycles; one o_Rx_DV pulse with o_Rx_Byte=0x68; o_Tx_Done pulses once.
REQ-032 Hold i_Tx_DV=1 with 0x68, change to 0x65 ('e') mid-frame -> current frame still received as 0x68; the following frames are received as 0x65, back-to-back per REQ-018.
REQ-033 Drive i_Rx_Serial low for CLKS_PER_BIT/4 cycles, then high -> no o_Rx_DV; the receiver returns to IDLE and then correctly receives a following 0xA5 frame.
REQ-034 Send a frame with the stop bit forced to 0, then line high -> no o_Rx_DV, o_Rx_Byte retains its previous value; the next valid 0x3C frame is received.
REQ-035 Assert i_Reset during DATA of a TX frame -> o_Tx_Serial=1 and o_Tx_Active=0 without waiting for a clock edge, no o_Rx_DV; a new 0x55 frame after release is received correctly.

Source files
------------

// File: rtl/uart_if.sv
`timescale 1ns/1ps
// UART pin bundle: transmit request/byte, transmit status and serial line, receive serial line and received byte.
// Latency: none (wires only); the slave side is the UART core, the master side is whatever drives and observes it.
// Backpressure: i_Tx_DV is only honoured while o_Tx_Active is low; receive has no backpressure (o_Rx_DV is a pulse).
interface uart_if;
    logic       i_Tx_DV;      // transmit request
    logic [7:0] i_Tx_Byte;    // byte to transmit, captured on acceptance
    logic       o_Tx_Active;  // frame in progress
    logic       o_Tx_Serial;  // transmit line, idle high
    logic       o_Tx_Done;    // one-cycle end-of-frame pulse
    logic       i_Rx_Serial;  // asynchronous receive line, idle high
    logic       o_Rx_DV;      // one-cycle received-byte pulse
    logic [7:0] o_Rx_Byte;    // last good received byte

    modport slave (
        input  i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
        output o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte
    );

    modport master (
        output i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
        input  o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte
    );
endinterface

// File: rtl/uart.sv
`timescale 1ns/1ps
// 8N1 UART with independent transmitter and receiver; ports: i_Clock, i_Reset (async, active high), bus (uart_if.slave).
// Latency: TX line follows acceptance on the same edge; frame = 10*CLKS_PER_BIT cycles plus CLEANUP and IDLE; RX byte valid at stop-bit midpoint.
// Backpressure: TX requests are ignored while a frame is active; RX has none, o_Rx_DV is a single-cycle pulse.
module uart #(
    parameter int CLKS_PER_BIT = 234   // clock cycles per bit, must be >= 4
) (
    input  logic    i_Clock,
    input  logic    i_Reset,
    uart_if.slave   bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT - 1) / 2);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_CLEANUP
    } tx_state_t;

    tx_state_t      tx_state_q, tx_state_d;
    logic [CW-1:0]  tx_cnt_q,   tx_cnt_d;
    logic [2:0]     tx_idx_q,   tx_idx_d;
    logic [7:0]     tx_data_q,  tx_data_d;
    logic           tx_serial_q, tx_serial_d;
    logic           tx_active_q, tx_active_d;
    logic           tx_done_q,   tx_done_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;

        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_idx_d = '0;
                if (bus.i_Tx_DV) begin
                    tx_data_d  = bus.i_Tx_Byte;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        tx_idx_d   = '0;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_CLEANUP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_CLEANUP: tx_state_d = TX_IDLE;
            default:    tx_state_d = TX_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so the
        // line is glitch-free yet changes on the same edge as the state.
        tx_serial_d = 1'b1;
        tx_active_d = 1'b0;
        tx_done_d   = 1'b0;
        case (tx_state_d)
            TX_START: begin
                tx_serial_d = 1'b0;
                tx_active_d = 1'b1;
            end
            TX_DATA: begin
                tx_serial_d = tx_data_d[tx_idx_d];
                tx_active_d = 1'b1;
            end
            TX_STOP:    tx_active_d = 1'b1;
            TX_CLEANUP: tx_done_d   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_idx_q    <= '0;
            tx_data_q   <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tx_data_q   <= tx_data_d;
            tx_serial_q <= tx_serial_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign bus.o_Tx_Serial = tx_serial_q;
    assign bus.o_Tx_Active = tx_active_q;
    assign bus.o_Tx_Done   = tx_done_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE
    } rx_state_t;

    // Two-flop synchronizer; both stages reset to the idle (high) level so
    // reset release never looks like a start bit.
    logic           rx_meta_q, rx_meta_d;
    logic           rx_sync_q, rx_sync_d;

    rx_state_t      rx_state_q, rx_state_d;
    logic [CW-1:0]  rx_cnt_q,   rx_cnt_d;
    logic [2:0]     rx_idx_q,   rx_idx_d;
    logic [7:0]     rx_shift_q, rx_shift_d;
    logic [7:0]     rx_byte_q,  rx_byte_d;
    logic           rx_dv_q,    rx_dv_d;

    always_comb begin
        rx_meta_d  = bus.i_Rx_Serial;
        rx_sync_d  = rx_meta_q;

        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_idx_d = '0;
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // Re-check the line at mid start bit to reject glitches;
                // all later samples are then taken at bit centres.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};  // LSB arrives first
                    if (rx_idx_q == 3'd7) begin
                        rx_idx_d   = '0;
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_byte_d  = rx_shift_q;
                        rx_dv_d    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        // Framing error: drop the byte and wait out the low line.
                        rx_state_d = RX_WAIT_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_WAIT_IDLE: if (rx_sync_q) rx_state_d = RX_IDLE;
            default:      rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_dv_q    <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_dv_q    <= rx_dv_d;
        end
    end

    assign bus.o_Rx_DV   = rx_dv_q;
    assign bus.o_Rx_Byte = rx_byte_q;

endmodule

// File: tb/tb_uart.sv
`timescale 1ns/1ps
// Bench for uart: loopback and bit-banged frames, checked against a frame-level model of the 8N1 line.
// Latency: expected line levels derived from bit positions counted from the request acceptance edge.
// Backpressure: exercises held requests, mid-frame byte changes, glitches, framing errors and mid-frame reset.
module tb_uart;

    localparam int CPB = 234;
    localparam int FRAME = 10 * CPB;   // start + 8 data + stop
    localparam int PERIOD = FRAME + 2; // plus CLEANUP and IDLE when back-to-back

    logic clk = 1'b0;
    logic rst;
    logic loop_en;
    logic tb_rx;

    uart_if bus();

    assign bus.i_Rx_Serial = loop_en ? bus.o_Tx_Serial : tb_rx;

    uart #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cur   = 0;          // cycles since the acceptance edge of the current TX sequence
    int done_cnt = 0;
    int exp_done = 0;
    logic [7:0] last_byte;  // model of o_Rx_Byte
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    // Observed receive pulses and transmit-done pulses.
    always @(negedge clk) begin
        if (bus.o_Rx_DV === 1'b1) rx_q.push_back(bus.o_Rx_Byte);
        if (bus.o_Tx_Done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level of bit k of an 8N1 frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic wait_to(input int off);
        while (cur < off) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic tx_begin(input logic [7:0] b, input bit hold);
        loop_en = 1'b1;
        @(negedge clk);
        bus.i_Tx_DV   = 1'b1;
        bus.i_Tx_Byte = b;
        @(negedge clk);
        cur = 0;
        if (!hold) bus.i_Tx_DV = 1'b0;
    endtask

    // Checks the centre of bits k_lo..k_hi of a frame accepted at offset base.
    task automatic chk_frame(input int base, input logic [7:0] b, input int k_lo, input int k_hi);
        for (int k = k_lo; k <= k_hi; k++) begin
            wait_to(base + k * CPB + CPB / 2);
            chk($sformatf("tx_bit%0d_%02h", k, b), bus.o_Tx_Serial, frame_bit(b, k));
            chk($sformatf("tx_active_bit%0d", k), bus.o_Tx_Active, 1'b1);
        end
    endtask

    // After the stop bit: one CLEANUP cycle, one IDLE cycle, then either a new start bit or idle.
    task automatic chk_gap(input int base, input bit next_start);
        wait_to(base + FRAME);
        chk("cleanup_serial", bus.o_Tx_Serial, 1'b1);
        chk("cleanup_done",   bus.o_Tx_Done,   1'b1);
        chk("cleanup_active", bus.o_Tx_Active, 1'b0);
        wait_to(base + FRAME + 1);
        chk("idle_serial", bus.o_Tx_Serial, 1'b1);
        chk("idle_done",   bus.o_Tx_Done,   1'b0);
        chk("idle_active", bus.o_Tx_Active, 1'b0);
        wait_to(base + FRAME + 2);
        chk("next_serial", bus.o_Tx_Serial, next_start ? 1'b0 : 1'b1);
        chk("next_active", bus.o_Tx_Active, next_start);
    endtask

    task automatic expect_rx(input logic [7:0] b);
        exp_q.push_back(b);
        last_byte = b;
    endtask

    task automatic check_rx(input string tag);
        int n;
        chk({tag, "_rx_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_rx_byte%0d", tag, i), rx_q[i], exp_q[i]);
        chk({tag, "_rx_hold"}, bus.o_Rx_Byte, last_byte);
        chk({tag, "_done_count"}, done_cnt, exp_done);
        rx_q.delete();
        exp_q.delete();
    endtask

    // Single loopback frame with full line check.
    task automatic loop_frame(input logic [7:0] b, input string tag);
        tx_begin(b, 1'b0);
        chk_frame(0, b, 0, 9);
        chk_gap(0, 1'b0);
        expect_rx(b);
        exp_done++;
        repeat (CPB) @(negedge clk);
        check_rx(tag);
    endtask

    // Drive a frame directly on the receive line.
    task automatic rx_send(input logic [7:0] b, input logic stop);
        loop_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tb_rx = (k == 9) ? stop : frame_bit(b, k);
            repeat (CPB) @(negedge clk);
        end
        tb_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rb;

        rst           = 1'b1;
        loop_en       = 1'b1;
        tb_rx         = 1'b1;
        bus.i_Tx_DV   = 1'b0;
        bus.i_Tx_Byte = 8'h00;
        last_byte     = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_serial", bus.o_Tx_Serial, 1'b1);
        chk("rst_active", bus.o_Tx_Active, 1'b0);
        chk("rst_done",   bus.o_Tx_Done,   1'b0);
        chk("rst_rx_dv",  bus.o_Rx_DV,     1'b0);
        chk("rst_rx_byte", bus.o_Rx_Byte,  8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Loopback of 'h'
        loop_frame(8'h68, "loop_68");

        // Random loopback bytes
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            loop_frame(rb, $sformatf("loop_rand%0d", i));
        end

        // Held request, byte changed mid-frame: 'h' then 'e','e' back-to-back
        tx_begin(8'h68, 1'b1);
        chk_frame(0, 8'h68, 0, 4);
        bus.i_Tx_Byte = 8'h65;
        chk_frame(0, 8'h68, 5, 9);
        chk_gap(0, 1'b1);
        chk_frame(PERIOD, 8'h65, 0, 9);
        chk_gap(PERIOD, 1'b1);
        chk_frame(2 * PERIOD, 8'h65, 0, 4);
        bus.i_Tx_DV = 1'b0;
        chk_frame(2 * PERIOD, 8'h65, 5, 9);
        chk_gap(2 * PERIOD, 1'b0);
        expect_rx(8'h68);
        expect_rx(8'h65);
        expect_rx(8'h65);
        exp_done += 3;
        repeat (CPB) @(negedge clk);
        check_rx("b2b");

        // Short low glitch on the receive line, then a good frame
        loop_en = 1'b0;
        tb_rx   = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        tb_rx   = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_rx("glitch");
        rx_send(8'hA5, 1'b1);
        expect_rx(8'hA5);
        check_rx("after_glitch");

        // Random bit-banged frame
        rb = 8'($urandom_range(0, 255));
        rx_send(rb, 1'b1);
        expect_rx(rb);
        check_rx("rx_rand");

        // Framing error: byte dropped, previous byte held, then a good frame
        rb = 8'($urandom_range(0, 255));
        rx_send(rb, 1'b0);
        check_rx("framing_err");
        rx_send(8'h3C, 1'b1);
        expect_rx(8'h3C);
        check_rx("after_framing");

        // Reset during the DATA phase of a loopback frame
        tx_begin(8'hF0, 1'b0);
        wait_to(3 * CPB + 10);
        rst = 1'b1;
        #1;
        chk("midrst_serial", bus.o_Tx_Serial, 1'b1);
        chk("midrst_active", bus.o_Tx_Active, 1'b0);
        chk("midrst_done",   bus.o_Tx_Done,   1'b0);
        chk("midrst_rx_dv",  bus.o_Rx_DV,     1'b0);
        last_byte = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check_rx("midrst");
        loop_frame(8'h55, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
